spynet_scheduler: RTL and testbench
===================================

SPYNET_SCHEDULER -- requirements
Module: spynet_scheduler

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 5: convolution layers per pyramid stage; net_type takes values 0..NUM_LAYERS-1.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: idle gap between net_done and the next net_start; range 1..15.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit in WAIT; 16-bit.
REQ-004 SHALL have one clock and an asynchronous active-high reset; the clock is named clk and the reset is named rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 run  input  1  one-cycle request to start a full pyramid pass; honoured only in IDLE.
REQ-008 abort  input  1  synchronous abort; returns the block to IDLE.
REQ-009 num_stages  input  3  pyramid stages to run, sampled when run is accepted; 0 is treated as 1; values above 5 are clamped to 5.
REQ-010 net_done  input  1  layer-complete flag from evaluate_network.
REQ-011 net_start  output  1  one-cycle pulse that launches one layer.
REQ-012 net_stage  output  3  current pyramid stage, 0-based.
REQ-013 net_type  output  3  current layer index, 0-based.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 pass_done  output  1  one-cycle pulse when the final layer of the final stage completes.
REQ-016 err  output  1  sticky watchdog error flag.

Function
REQ-017 The FSM SHALL have states IDLE, LAUNCH, WAIT, SETTLE and FINISH, all registered.
REQ-018 IDLE: run=1 with abort=0 SHALL latch the clamped num_stages, set stage=0 and type=0, clear err, and go to LAUNCH.
REQ-019 LAUNCH SHALL assert net_start for exactly one cycle and go to WAIT.
REQ-020 WAIT: net_done=1 SHALL load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
REQ-021 SETTLE SHALL count down to 0, then select exactly one next state:
- type<NUM_LAYERS-1: type+1, go to LAUNCH.
- otherwise, stage<latched stages-1: stage+1, type=0, go to LAUNCH.
- otherwise: go to FINISH.
REQ-022 FINISH SHALL assert pass_done for one cycle and go to IDLE.
REQ-023 net_stage and net_type SHALL be stable from LAUNCH through SETTLE and change only on the SETTLE exit.
REQ-024 Latency: net_done sampled in WAIT in cycle N SHALL produce the next net_start in cycle N+1+SETTLE_CYCLES.
REQ-025 Timing of a single-layer pass: pass_done SHALL assert SETTLE_CYCLES+1 cycles after net_done is sampled.
REQ-026 net_done outside WAIT SHALL be ignored; a net_done coinciding with net_start SHALL be ignored.
REQ-027 run while busy=1 SHALL be ignored.
REQ-028 abort=1 in any state SHALL force IDLE next cycle with no pass_done, and net_stage/net_type SHALL clear to 0.
REQ-029 Simultaneous run and abort in IDLE: abort SHALL win.
REQ-030 Total net_start pulses per completed pass SHALL equal latched stages x NUM_LAYERS.

Reset
REQ-031 On rst=1 the block SHALL asynchronously force IDLE, net_start=0, net_stage=0, net_type=0, busy=0, pass_done=0 and err=0, and clear all counters.
REQ-032 rst asserted mid-pass SHALL discard the pass; after release the block SHALL wait for a new run.

Configuration
REQ-033 Macro SPYNET_SCHED_TIMEOUT_EN defined: a 16-bit counter SHALL increment in WAIT and clear on entry to WAIT.
- Reaching TIMEOUT_CYCLES without net_done SHALL set err and go to IDLE with no pass_done.
- err SHALL stay set until rst or the next accepted run.
REQ-034 Macro SPYNET_SCHED_TIMEOUT_EN undefined: no watchdog counter SHALL exist, err SHALL be tied to 0, and WAIT SHALL hold indefinitely.

Verification
REQ-035 run with num_stages=3, net_done 10 cycles after each net_start -> 15 net_start pulses, (stage,type) sequence (0,0)..(2,4), exactly one pass_done, then busy=0.
REQ-036 num_stages=0, NUM_LAYERS=5 -> 5 net_start pulses, all with net_stage=0; num_stages=7 -> 25 pulses.
REQ-037 net_done sampled in cycle 100, SETTLE_CYCLES=2 -> next net_start in cycle 103; a stray net_done in IDLE or SETTLE -> no state change.
REQ-038 abort during stage 1 type 2 WAIT -> IDLE next cycle, busy=0, no pass_done; a run issued 1 cycle after abort -> new pass starting at (0,0).
REQ-039 SPYNET_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=50, net_done withheld -> err=1 and busy=0 after 50 WAIT cycles; next run -> err=0.
REQ-040 rst asserted mid-SETTLE -> all outputs 0 immediately, without waiting for a clock edge; run accepted after rst release.

Source files
------------

// File: rtl/spynet_scheduler.sv
// SpyNet layer scheduler: walks (stage, layer) pairs over evaluate_network with a settle gap.
// Optional WAIT watchdog enabled by defining SPYNET_SCHED_TIMEOUT_EN.
module spynet_scheduler #(
  parameter int NUM_LAYERS     = 5,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       abort,
  input  logic [2:0] num_stages,
  input  logic       net_done,
  output logic       net_start,
  output logic [2:0] net_stage,
  output logic [2:0] net_type,
  output logic       busy,
  output logic       pass_done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, FINISH} state_t;

  localparam logic [2:0] LAST_LAYER  = 3'(NUM_LAYERS - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 8) begin : g_bad_layers
    $error("NUM_LAYERS must be 1..8");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  function automatic logic [2:0] clamp_stages(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > 3'd5)  return 3'd5;
    return n;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [2:0] layer_q, layer_d;
  logic [2:0] stages_q, stages_d;
  logic [3:0] settle_q, settle_d;

`ifdef SPYNET_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      stage_q  <= 3'd0;
      layer_q  <= 3'd0;
      stages_q <= 3'd1;
      settle_q <= 4'd0;
`ifdef SPYNET_SCHED_TIMEOUT_EN
      wd_q     <= 16'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      layer_q  <= layer_d;
      stages_q <= stages_d;
      settle_q <= settle_d;
`ifdef SPYNET_SCHED_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    layer_d  = layer_q;
    stages_d = stages_q;
    settle_d = settle_q;
`ifdef SPYNET_SCHED_TIMEOUT_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (run) begin
          stages_d = clamp_stages(num_stages);
          stage_d  = 3'd0;
          layer_d  = 3'd0;
          state_d  = LAUNCH;
`ifdef SPYNET_SCHED_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef SPYNET_SCHED_TIMEOUT_EN
        wd_d    = 16'd0;
`endif
      end
      WAIT: begin
        if (net_done) begin
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end
`ifdef SPYNET_SCHED_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      SETTLE: begin
        // Position only advances on the SETTLE exit so the outputs stay stable for a whole layer.
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else if (layer_q < LAST_LAYER) begin
          layer_d = layer_q + 3'd1;
          state_d = LAUNCH;
        end else if (stage_q + 3'd1 < stages_q) begin
          stage_d = stage_q + 3'd1;
          layer_d = 3'd0;
          state_d = LAUNCH;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition, including a run arriving in IDLE.
    if (abort) begin
      state_d = IDLE;
      stage_d = 3'd0;
      layer_d = 3'd0;
    end
  end

  assign net_start = (state_q == LAUNCH);
  assign pass_done = (state_q == FINISH);
  assign busy      = (state_q != IDLE);
  assign net_stage = stage_q;
  assign net_type  = layer_q;

`ifdef SPYNET_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spynet_scheduler.sv
// Self-checking bench for spynet_scheduler: event-timeline model plus directed scenarios.
module tb_spynet_scheduler;

  localparam int NL  = 5;
  localparam int SC  = 2;
  localparam int TO  = 50;

  logic       clk = 1'b0;
  logic       rst, run, abort, net_done;
  logic [2:0] num_stages;
  logic       net_start, busy, pass_done, err;
  logic [2:0] net_stage, net_type;

  logic man_done, auto_done, auto_en;
  int   auto_gap, done_at;

  assign net_done = man_done | auto_done;

  spynet_scheduler #(.NUM_LAYERS(NL), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort), .num_stages(num_stages),
    .net_done(net_done), .net_start(net_start), .net_stage(net_stage),
    .net_type(net_type), .busy(busy), .pass_done(pass_done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: a pass is the list idx = 0..total-1 with (stage, layer) = (idx / NL, idx % NL);
  // events are scheduled by absolute cycle number.
  bit m_busy, m_err, m_done_seen;
  int m_launch_at, m_finish_at, m_idx, m_total, m_stage, m_type;

  int n_starts, n_pass, stage_acc, last_start_cyc;
  logic [5:0] last_pair;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    int ns;
    if (rst) begin
      m_busy = 0; m_err = 0; m_done_seen = 0;
      m_stage = 0; m_type = 0; m_launch_at = -1; m_finish_at = -1;
    end else if (abort) begin
      m_busy = 0; m_done_seen = 0;
      m_stage = 0; m_type = 0; m_launch_at = -1; m_finish_at = -1;
    end else if (!m_busy) begin
      if (run) begin
        ns = int'(num_stages);
        if (ns == 0) ns = 1;
        if (ns > 5) ns = 5;
        m_total = ns * NL;
        m_idx = 0; m_stage = 0; m_type = 0; m_err = 0;
        m_busy = 1; m_done_seen = 0;
        m_launch_at = cyc + 1; m_finish_at = -1;
      end
    end else begin
      if (cyc == m_finish_at) begin
        m_busy = 0;
      end else if (!m_done_seen && cyc > m_launch_at) begin
        if (net_done) begin
          m_done_seen = 1;
          if (m_idx + 1 < m_total) m_launch_at = cyc + 1 + SC;
          else                     m_finish_at = cyc + 1 + SC;
        end
`ifdef SPYNET_SCHED_TIMEOUT_EN
        else if (cyc == m_launch_at + TO) begin
          m_busy = 0;
          m_err = 1;
        end
`endif
      end
      if (m_busy && m_done_seen && cyc + 1 == m_launch_at) begin
        m_idx++;
        m_stage = m_idx / NL;
        m_type = m_idx % NL;
        m_done_seen = 0;
      end
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [9:0] act, exp;
    @(negedge clk);
    if (!rst) begin
      exp = {m_busy && cyc == m_launch_at, m_busy && cyc == m_finish_at, m_busy, m_err,
             3'(m_stage), 3'(m_type)};
      act = {net_start, pass_done, busy, err, net_stage, net_type};
      check("cycle_model", 32'(act), 32'(exp));
      if (net_start) begin
        n_starts++;
        last_pair = {net_stage, net_type};
        stage_acc += int'(net_stage);
        last_start_cyc = cyc;
        if (auto_en) done_at = cyc + auto_gap;
      end
      if (pass_done) n_pass++;
    end
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    auto_done = auto_en && (cyc == done_at);
  endtask

  task automatic pulse_run(input logic [2:0] ns);
    num_stages = ns;
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_start(input string name, input logic [2:0] s, input logic [2:0] t,
                            input int budget);
    int k = 0;
    while (!(net_start && net_stage == s && net_type == t) && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(net_start && net_stage == s && net_type == t), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1, "bench stalled");
  end

  initial begin
    int s0, p0, a0, t;
    rst = 1'b1; run = 1'b0; abort = 1'b0; num_stages = 3'd0;
    man_done = 1'b0; auto_done = 1'b0; auto_en = 1'b0; auto_gap = 10; done_at = -1;
    n_starts = 0; n_pass = 0; stage_acc = 0; last_start_cyc = -1; last_pair = '0;
    m_busy = 0; m_err = 0; m_done_seen = 0; m_launch_at = -1; m_finish_at = -1;
    m_idx = 0; m_total = 0; m_stage = 0; m_type = 0;

    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({net_start, pass_done, err, net_stage, net_type}), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Three-stage pass with a 10-cycle layer, plus a run while busy that must be ignored.
    auto_en = 1'b1; auto_gap = 10;
    s0 = n_starts; p0 = n_pass;
    pulse_run(3'd3);
    check("A_first_start", 32'({net_start, net_stage, net_type}), 32'({1'b1, 6'd0}));
    repeat (20) step();
    pulse_run(3'd1);
    wait_idle("A_idle", 600);
    check("A_starts", 32'(n_starts - s0), 32'd15);
    check("A_pass", 32'(n_pass - p0), 32'd1);
    check("A_last_pair", 32'(last_pair), 32'({3'd2, 3'd4}));

    // Stage-count clamping.
    s0 = n_starts; a0 = stage_acc;
    pulse_run(3'd0);
    wait_idle("B0_idle", 300);
    check("B0_starts", 32'(n_starts - s0), 32'd5);
    check("B0_stage_sum", 32'(stage_acc - a0), 32'd0);
    s0 = n_starts; a0 = stage_acc;
    pulse_run(3'd7);
    wait_idle("B7_idle", 600);
    check("B7_starts", 32'(n_starts - s0), 32'd25);
    check("B7_stage_sum", 32'(stage_acc - a0), 32'd50);

    // Done-to-start latency; stray done in SETTLE, on net_start, and in IDLE.
    auto_en = 1'b0;
    pulse_run(3'd1);
    repeat (4) step();
    t = cyc;
    man_done = 1'b1;
    auto_en = 1'b1;
    repeat (4) step();
    man_done = 1'b0;
    check("C_latency", 32'(last_start_cyc - t), 32'd3);
    check("C_next_type", 32'(net_type), 32'd1);
    wait_idle("C_idle", 300);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    step();
    check("C_stray_idle", 32'(busy), 32'd0);

    // Abort in WAIT of (1,2), then a run one cycle later.
    s0 = n_starts; p0 = n_pass;
    pulse_run(3'd3);
    wait_start("D_reach_1_2", 3'd1, 3'd2, 400);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("D_abort_busy", 32'(busy), 32'd0);
    check("D_abort_pos", 32'({pass_done, net_stage, net_type}), 32'd0);
    s0 = n_starts;
    pulse_run(3'd2);
    check("D_restart", 32'({net_start, net_stage, net_type}), 32'({1'b1, 6'd0}));
    wait_idle("D_idle", 600);
    check("D_pass", 32'(n_pass - p0), 32'd1);
    check("D_starts", 32'(n_starts - s0), 32'd10);
    num_stages = 3'd1; run = 1'b1; abort = 1'b1;
    step();
    run = 1'b0; abort = 1'b0;
    check("D_run_abort", 32'(busy), 32'd0);
    step();

    // Watchdog, or indefinite WAIT when it is not built in.
    auto_en = 1'b0;
    pulse_run(3'd1);
`ifdef SPYNET_SCHED_TIMEOUT_EN
    repeat (50) step();
    check("E_still_wait", 32'(busy), 32'd1);
    step();
    check("E_timeout", 32'({busy, err}), 32'({1'b0, 1'b1}));
    repeat (2) step();
    check("E_err_sticky", 32'(err), 32'd1);
    pulse_run(3'd1);
    check("E_err_clear", 32'({busy, err}), 32'({1'b1, 1'b0}));
`else
    repeat (60) step();
    check("E_hold", 32'({busy, err}), 32'({1'b1, 1'b0}));
`endif
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("E_aborted", 32'(busy), 32'd0);

    // Asynchronous reset while in SETTLE of (1,3).
    auto_en = 1'b1; auto_gap = 3;
    pulse_run(3'd2);
    wait_start("F_reach_1_3", 3'd1, 3'd3, 400);
    repeat (4) step();
    check("F_in_pass", 32'({busy, net_stage, net_type}), 32'({1'b1, 3'd1, 3'd3}));
    #2;
    rst = 1'b1;
    #1;
    check("F_async_busy", 32'(busy), 32'd0);
    check("F_async_outs", 32'({net_start, pass_done, err, net_stage, net_type}), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("F_stays_idle", 32'(busy), 32'd0);
    s0 = n_starts;
    pulse_run(3'd1);
    check("F_new_run", 32'({net_start, net_stage, net_type}), 32'({1'b1, 6'd0}));
    wait_idle("F_idle", 300);
    check("F_starts", 32'(n_starts - s0), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
